uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, FIFO capacity in bytes (power of two, >=8).
REQ-002 SHALL have parameter AW, default 8, giving log2(DEPTH).
REQ-003 SHALL have port clk_i  input  1  clock; all logic samples on the rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr_i  input  1  synchronous flush of FIFO and controller.
REQ-006 SHALL have port wr_req_i  input  1  bus word-write request (4 bytes).
REQ-007 SHALL have port wr_data_i  input  32  word; byte 0 = bits 7:0, transmitted first.
REQ-008 SHALL have port wr_ready_o  output  1  high when at least 4 bytes are free.
REQ-009 SHALL have port tx_en_i  input  1  drain enable.
REQ-010 SHALL have port fifo_we_o  output  1  FIFO word write strobe.
REQ-011 SHALL have port fifo_wdata_o  output  32  equals wr_data_i.
REQ-012 SHALL have port fifo_re_o  output  1  FIFO byte read strobe.
REQ-013 SHALL have port fifo_rdata_i  input  8  FIFO byte, valid combinationally in the cycle fifo_re_o is high.
REQ-014 SHALL have port fifo_clr_o  output  1  FIFO flush strobe.
REQ-015 SHALL have port tx_start_o  output  1  one-cycle start pulse to the UART TX core.
REQ-016 SHALL have port tx_byte_o  output  8  byte to transmit, held stable from start until done.
REQ-017 SHALL have port tx_busy_i  input  1  TX core busy.
REQ-018 SHALL have port tx_done_i  input  1  one-cycle pulse when a byte completes.
REQ-019 SHALL have port level_o  output  AW+1  bytes currently stored.
REQ-020 SHALL have port empty_o / full_o  output  1 each  level_o==0 / level_o==DEPTH.
REQ-021 SHALL have port irq_o  output  1  drain-complete interrupt pulse.

Function
REQ-022 SHALL accept a write (fifo_we_o=1) exactly when wr_req_i & wr_ready_o & ~clr_i, with wr_ready_o = (level <= DEPTH-4).
REQ-023 SHALL ignore wr_req_i when wr_ready_o=0; the data is dropped and level_o is unchanged.
REQ-024 SHALL implement the FSM IDLE -> FETCH -> SEND -> WAIT -> IDLE.
REQ-025 In IDLE, SHALL go to FETCH when tx_en_i=1 and level>0.
REQ-026 In FETCH, SHALL assert fifo_re_o for exactly one cycle, register fifo_rdata_i into tx_byte_o, and go to SEND.
REQ-027 In SEND, SHALL assert tx_start_o for one cycle when tx_busy_i=0, then go to WAIT; while tx_busy_i=1 it SHALL stay in SEND with tx_start_o=0.
REQ-028 In WAIT, on tx_done_i SHALL go to FETCH if tx_en_i=1 and level>0, otherwise to IDLE.
REQ-029 Clearing tx_en_i SHALL stop the FSM only at the IDLE decision points; a byte already fetched SHALL still be sent.
REQ-030 SHALL update the level counter by +4 on an accepted write, -1 on fifo_re_o, and +3 when both occur in the same cycle.
REQ-031 SHALL never let the level counter underflow below 0 or overflow above DEPTH.
REQ-032 On clr_i, SHALL pulse fifo_clr_o for one cycle, zero the level counter, and force the FSM to IDLE from any state with no tx_start_o that cycle; clr_i SHALL take priority over a simultaneous write or read.
REQ-033 After clr_i, SHALL not issue tx_start_o for an in-flight fetched byte; a tx_done_i arriving in IDLE SHALL be ignored.
REQ-034 Latency: the first tx_start_o SHALL occur 2 cycles after the first write is accepted, given tx_en_i=1 and tx_busy_i=0.

Reset
REQ-035 On rst_ni low, SHALL set FSM=IDLE, level=0, tx_byte_o=0, and all strobes plus irq_o to 0, with wr_ready_o=1, empty_o=1 and full_o=0.
REQ-036 Reset asserted mid-transmission SHALL abandon the byte with no further tx_start_o.

Configuration
REQ-037 With macro UART_TX_CTRL_IRQ_EN defined, SHALL pulse irq_o for one cycle on the tx_done_i that occurs when level==0, i.e. the FIFO is drained.
REQ-038 Without UART_TX_CTRL_IRQ_EN, irq_o SHALL be tied to 0 and no interrupt logic SHALL be instantiated.

Verification
REQ-039 Write 0x44332211 with tx_en_i=1 and the TX core answering done 10 cycles after start -> tx_byte_o shows 0x11, 0x22, 0x33, 0x44 in order; level_o counts 4,3,2,1,0; irq_o pulses once (IRQ_EN).
REQ-040 Do 64 writes with tx_en_i=0 -> level_o=256, full_o=1, wr_ready_o=0 from level 253 up; a 65th write is dropped.
REQ-041 Write and FETCH in the same cycle at level 5 -> level_o=8 next cycle.
REQ-042 Hold tx_busy_i=1 for 20 cycles while in SEND -> tx_start_o stays 0, then pulses once the cycle after busy falls.
REQ-043 Assert clr_i during WAIT at level 6 -> fifo_clr_o pulses, level_o=0, FSM=IDLE, and the late tx_done_i is ignored.
REQ-044 Drive rst_ni low mid-SEND -> all outputs take their REQ-035 values asynchronously.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART TX controller: accepts 32-bit word writes into an external byte FIFO and drains it
// byte by byte into a UART TX core. Define UART_TX_CTRL_IRQ_EN to enable the drain interrupt.
module uart_tx_ctrl #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          wr_req_i,
  input  logic [31:0]   wr_data_i,
  output logic          wr_ready_o,
  input  logic          tx_en_i,
  output logic          fifo_we_o,
  output logic [31:0]   fifo_wdata_o,
  output logic          fifo_re_o,
  input  logic [7:0]    fifo_rdata_i,
  output logic          fifo_clr_o,
  output logic          tx_start_o,
  output logic [7:0]    tx_byte_o,
  input  logic          tx_busy_i,
  input  logic          tx_done_i,
  output logic [AW:0]   level_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          irq_o
);

  localparam logic [AW:0] LevelMax = (AW+1)'(DEPTH);
  localparam logic [AW:0] ReadyMax = (AW+1)'(DEPTH - 4);
  localparam logic [AW:0] LvlOne   = (AW+1)'(1);
  localparam logic [AW:0] LvlThree = (AW+1)'(3);
  localparam logic [AW:0] LvlFour  = (AW+1)'(4);

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StWait} state_e;

  state_e      state_q, state_d;
  logic [AW:0] level_q, level_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        level_nz;
  logic        avail;

  assign level_nz     = (level_q != '0);
  assign wr_ready_o   = (level_q <= ReadyMax);
  assign fifo_we_o    = wr_req_i & wr_ready_o & ~clr_i;
  assign fifo_wdata_o = wr_data_i;
  assign fifo_clr_o   = clr_i;
  assign level_o      = level_q;
  assign empty_o      = ~level_nz;
  assign full_o       = (level_q == LevelMax);
  assign tx_byte_o    = tx_byte_q;

  // A word accepted this cycle is readable next cycle, so it already counts as data to drain.
  assign avail = level_nz | fifo_we_o;

  always_comb begin
    state_d    = state_q;
    tx_byte_d  = tx_byte_q;
    fifo_re_o  = 1'b0;
    tx_start_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx_en_i && avail) state_d = StFetch;
      end
      StFetch: begin
        fifo_re_o = level_nz;
        tx_byte_d = fifo_rdata_i;
        state_d   = StSend;
      end
      StSend: begin
        if (!tx_busy_i) begin
          tx_start_o = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (tx_done_i) state_d = (tx_en_i && avail) ? StFetch : StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Flush wins over everything; a fetched-but-unsent byte is abandoned.
    if (clr_i) begin
      state_d    = StIdle;
      tx_byte_d  = tx_byte_q;
      fifo_re_o  = 1'b0;
      tx_start_o = 1'b0;
    end
  end

  always_comb begin
    level_d = level_q;
    if (clr_i) begin
      level_d = '0;
    end else begin
      case ({fifo_we_o, fifo_re_o})
        2'b10:   level_d = level_q + LvlFour;
        2'b01:   level_d = level_nz ? (level_q - LvlOne) : level_q;
        2'b11:   level_d = level_q + LvlThree;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      level_q   <= '0;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      tx_byte_q <= tx_byte_d;
    end
  end

`ifdef UART_TX_CTRL_IRQ_EN
  logic irq_q;

  // Only a completion of a byte actually in flight counts; stray done pulses in IDLE do not.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (state_q == StWait) & tx_done_i & ~level_nz & ~clr_i;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: byte-FIFO and TX-core models around the DUT, plus a
// transaction-level scoreboard checked every cycle and directed scenarios with literal checks.
module tb_uart_tx_ctrl;

  localparam int DEPTH   = 256;
  localparam int AW      = 8;
  localparam int DoneLat = 10;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clr_i = 1'b0;
  logic        wr_req_i = 1'b0;
  logic [31:0] wr_data_i = '0;
  logic        tx_en_i = 1'b0;
  logic        wr_ready_o, fifo_we_o, fifo_re_o, fifo_clr_o, tx_start_o;
  logic [31:0] fifo_wdata_o;
  logic [7:0]  fifo_rdata_i, tx_byte_o;
  logic        tx_busy_i, tx_done_i;
  logic [AW:0] level_o;
  logic        empty_o, full_o, irq_o;

  uart_tx_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (clr_i),
    .wr_req_i     (wr_req_i),
    .wr_data_i    (wr_data_i),
    .wr_ready_o   (wr_ready_o),
    .tx_en_i      (tx_en_i),
    .fifo_we_o    (fifo_we_o),
    .fifo_wdata_o (fifo_wdata_o),
    .fifo_re_o    (fifo_re_o),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_clr_o   (fifo_clr_o),
    .tx_start_o   (tx_start_o),
    .tx_byte_o    (tx_byte_o),
    .tx_busy_i    (tx_busy_i),
    .tx_done_i    (tx_done_i),
    .level_o      (level_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Environment: byte FIFO storage and a TX core that finishes DoneLat cycles after start.
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = '0;
  logic [7:0] rd_ptr = '0;
  logic       core_busy = 1'b0;
  logic       core_done = 1'b0;
  logic       hold_busy = 1'b0;
  int         core_cnt = 0;

  assign fifo_rdata_i = mem[rd_ptr];
  assign tx_busy_i    = core_busy | hold_busy;
  assign tx_done_i    = core_done;

  initial begin : env
    logic        s_we, s_re, s_clr, s_start;
    logic [31:0] s_wd;
    forever begin
      @(negedge clk_i);
      s_we = fifo_we_o; s_re = fifo_re_o; s_clr = fifo_clr_o; s_start = tx_start_o;
      s_wd = fifo_wdata_o;
      @(posedge clk_i);
      #1;
      core_done = 1'b0;
      if (!rst_ni) begin
        wr_ptr = '0; rd_ptr = '0; core_busy = 1'b0; core_cnt = 0;
      end else begin
        if (s_clr) begin
          wr_ptr = '0; rd_ptr = '0;
        end else begin
          if (s_we) begin
            for (int i = 0; i < 4; i++) begin
              mem[wr_ptr] = s_wd[8*i +: 8];
              wr_ptr = wr_ptr + 8'd1;
            end
          end
          if (s_re) rd_ptr = rd_ptr + 8'd1;
        end
        if (s_start) begin
          core_busy = 1'b1; core_cnt = DoneLat - 2;
        end else if (core_busy) begin
          if (core_cnt == 0) begin
            core_busy = 1'b0; core_done = 1'b1;
          end else begin
            core_cnt--;
          end
        end
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: level is bytes written minus bytes read; bytes leave in write order.
  int         m_level = 0;
  logic [7:0] exp_q [$];
  logic [7:0] pend = '0;
  bit         pend_v = 1'b0;
  bit         inflight = 1'b0;
  logic [7:0] fly_byte = '0;
  bit         exp_irq = 1'b0;
  logic [7:0] sent_log [$];
  int         lvl_log [$];
  int         last_lvl = 0;
  int         n_start = 0;
  int         n_irq = 0;
  int         ncyc = 0;
  bit         lat_arm = 1'b0;
  int         acc_cyc = -1;
  int         st_cyc = -1;

  initial begin : compare
    bit ewe;
    forever begin
      @(negedge clk_i);
      ncyc++;
      if (!rst_ni) begin
        chk("rst_level", level_o, 0);
        chk("rst_start", tx_start_o, 0);
        chk("rst_re", fifo_re_o, 0);
        chk("rst_byte", tx_byte_o, 0);
        chk("rst_ready", wr_ready_o, 1);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_irq", irq_o, 0);
        m_level = 0; exp_q.delete(); pend_v = 0; inflight = 0; exp_irq = 0; last_lvl = 0;
      end else begin
        ewe = wr_req_i && (m_level <= DEPTH - 4) && !clr_i;
        chk("we", fifo_we_o, ewe);
        chk("wdata", fifo_wdata_o, wr_data_i);
        chk("clr", fifo_clr_o, clr_i);
        chk("level", level_o, m_level);
        chk("ready", wr_ready_o, m_level <= DEPTH - 4);
        chk("empty", empty_o, m_level == 0);
        chk("full", full_o, m_level == DEPTH);
        chk("irq", irq_o, exp_irq);
        chk("re_legal", fifo_re_o && (m_level == 0 || clr_i), 0);
        if (irq_o) n_irq++;
        if (int'(level_o) != last_lvl) begin
          lvl_log.push_back(int'(level_o));
          last_lvl = int'(level_o);
        end
        if (inflight) chk("byte_hold", tx_byte_o, fly_byte);
        if (tx_start_o) begin
          chk("start_pend", pend_v, 1);
          chk("start_byte", tx_byte_o, pend);
          chk("start_busy", tx_busy_i, 0);
          sent_log.push_back(tx_byte_o);
          n_start++;
          if (lat_arm && st_cyc < 0) st_cyc = ncyc;
        end
        if (lat_arm && ewe && acc_cyc < 0) acc_cyc = ncyc;
`ifdef UART_TX_CTRL_IRQ_EN
        exp_irq = !clr_i && tx_done_i && inflight && (m_level == 0);
`else
        exp_irq = 1'b0;
`endif
        if (clr_i) begin
          m_level = 0; exp_q.delete(); pend_v = 0; inflight = 0;
        end else begin
          if (fifo_re_o && exp_q.size() > 0) begin
            pend = exp_q.pop_front(); pend_v = 1; m_level -= 1;
          end
          if (ewe) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(wr_data_i[8*i +: 8]);
            m_level += 4;
          end
          if (tx_start_o) begin
            pend_v = 0; inflight = 1; fly_byte = tx_byte_o;
          end else if (tx_done_i && inflight) begin
            inflight = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_word(input logic [31:0] d);
    wr_req_i = 1'b1; wr_data_i = d;
    step();
    wr_req_i = 1'b0;
  endtask

  task automatic do_clr();
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] t1_exp [4];
    int         t1_lvl [5];
    bit         found;
    int         starts0;
    t1_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    t1_lvl = '{4, 3, 2, 1, 0};

    repeat (3) step();
    rst_ni = 1'b1;
    step();

    // Single word drains in byte order with 2-cycle start latency.
    lvl_log.delete(); sent_log.delete(); n_irq = 0;
    lat_arm = 1; acc_cyc = -1; st_cyc = -1;
    tx_en_i = 1'b1;
    write_word(32'h44332211);
    for (int k = 0; k < 200 && sent_log.size() < 4; k++) step();
    repeat (15) step();
    lat_arm = 0;
    chk("t1_count", sent_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < sent_log.size()) chk("t1_byte", sent_log[i], t1_exp[i]);
    end
    chk("t1_lvl_count", lvl_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < lvl_log.size()) chk("t1_lvl", lvl_log[i], t1_lvl[i]);
    end
    chk("t1_latency", st_cyc - acc_cyc, 2);
`ifdef UART_TX_CTRL_IRQ_EN
    chk("t1_irq", n_irq, 1);
`else
    chk("t1_irq", n_irq, 0);
`endif

    // Fill to DEPTH with draining off; the 65th word is dropped.
    tx_en_i = 1'b0;
    do_clr();
    for (int i = 0; i < 64; i++) begin
      wr_req_i = 1'b1; wr_data_i = 32'(i) * 32'h01010101;
      @(negedge clk_i);
      chk("t2_ready", wr_ready_o, 1);
      chk("t2_we", fifo_we_o, 1);
      step();
    end
    wr_req_i = 1'b0;
    @(negedge clk_i);
    chk("t2_level", level_o, 256);
    chk("t2_full", full_o, 1);
    chk("t2_ready_full", wr_ready_o, 0);
    step();
    wr_req_i = 1'b1; wr_data_i = 32'hDEADBEEF;
    @(negedge clk_i);
    chk("t2_drop_we", fifo_we_o, 0);
    step();
    wr_req_i = 1'b0;
    @(negedge clk_i);
    chk("t2_drop_level", level_o, 256);
    step();
    tx_en_i = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk_i);
      if (level_o == 255) found = 1;
      else step();
    end
    chk("t2_found255", found, 1);
    chk("t2_ready255", wr_ready_o, 0);
    chk("t2_full255", full_o, 0);
    step();
    tx_en_i = 1'b0;
    do_clr();
    @(negedge clk_i);
    chk("t2_clr_level", level_o, 0);
    step();
    repeat (15) step();

    // Write lands in the same cycle as a FETCH at level 5.
    write_word(32'hA3A2A1A0);
    write_word(32'hB3B2B1B0);
    tx_en_i = 1'b1;
    found = 0;
    for (int k = 0; k < 150 && !found; k++) begin
      @(negedge clk_i);
      if (tx_done_i && level_o == 5) found = 1;
      else step();
    end
    chk("t3_found", found, 1);
    step();
    wr_req_i = 1'b1; wr_data_i = 32'hC3C2C1C0;
    @(negedge clk_i);
    chk("t3_re", fifo_re_o, 1);
    chk("t3_we", fifo_we_o, 1);
    chk("t3_lvl5", level_o, 5);
    step();
    wr_req_i = 1'b0;
    @(negedge clk_i);
    chk("t3_lvl8", level_o, 8);
    step();
    tx_en_i = 1'b0;
    do_clr();
    repeat (15) step();

    // Busy held for 20 cycles in SEND.
    hold_busy = 1'b1;
    write_word(32'h000000D5);
    tx_en_i = 1'b1;
    step();
    step();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      chk("t4_no_start", tx_start_o, 0);
      step();
    end
    hold_busy = 1'b0;
    @(negedge clk_i);
    chk("t4_start", tx_start_o, 1);
    chk("t4_byte", tx_byte_o, 8'hD5);
    step();
    @(negedge clk_i);
    chk("t4_once", tx_start_o, 0);
    step();
    repeat (15) step();
    tx_en_i = 1'b0;
    do_clr();

    // Flush during WAIT at level 6; the late done must be ignored.
    write_word(32'h13121110);
    write_word(32'h17161514);
    tx_en_i = 1'b1;
    found = 0;
    for (int k = 0; k < 150 && !found; k++) begin
      @(negedge clk_i);
      if (tx_start_o && level_o == 6) found = 1;
      else step();
    end
    chk("t5_found", found, 1);
    step();
    clr_i = 1'b1;
    @(negedge clk_i);
    chk("t5_clr", fifo_clr_o, 1);
    chk("t5_clr_start", tx_start_o, 0);
    chk("t5_clr_re", fifo_re_o, 0);
    step();
    clr_i = 1'b0;
    starts0 = n_start;
    repeat (20) step();
    chk("t5_no_start", n_start - starts0, 0);
    chk("t5_level", level_o, 0);
    chk("t5_empty", empty_o, 1);
    tx_en_i = 1'b0;

    // Asynchronous reset while stuck in SEND.
    hold_busy = 1'b1;
    write_word(32'h0000005A);
    tx_en_i = 1'b1;
    step();
    step();
    step();
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_level", level_o, 0);
    chk("t6_start", tx_start_o, 0);
    chk("t6_re", fifo_re_o, 0);
    chk("t6_byte", tx_byte_o, 0);
    chk("t6_ready", wr_ready_o, 1);
    chk("t6_empty", empty_o, 1);
    chk("t6_full", full_o, 0);
    chk("t6_irq", irq_o, 0);
    chk("t6_we", fifo_we_o, 0);
    chk("t6_clr", fifo_clr_o, 0);
    hold_busy = 1'b0;
    repeat (2) step();
    rst_ni = 1'b1;
    starts0 = n_start;
    repeat (20) step();
    chk("t6_no_start", n_start - starts0, 0);
    tx_en_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
